// File: rtl/cpu_pkg.sv
// Types and constants shared by the front-end pipeline stages.
// The IF/ID record defined here is also consumed by decode_stage.
package cpu_pkg;

    localparam logic [31:0] NOP = 32'hD503201F;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register that catches the instruction which completes
// while decode is stalled and IF/ID is already occupied.
module if_skid_buffer
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   unload_i,
    input  logic   clear_i,
    input  if_id_t data_i,
    output if_id_t data_o,
    output logic   full_o
);

    logic   full_q;
    if_id_t data_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else if (clear_i || unload_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
        end
    end

    // NOTE: only the occupancy flag is reset; the payload is ignored while empty.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, absorbs decode
// stalls through a one-entry skid and applies downstream redirects/flushes.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [63:0] if_id_pc,
    output logic [63:0] if_id_pc_plus4
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  pend_q, pend_d;
    if_id_t       if_id_q, if_id_d;

    logic [63:0]  pc_plus4;
    logic [63:0]  target;
    if_id_t       fetched;
    if_id_t       skid_data;
    logic         skid_full;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_clear;
    logic         handshake;
    logic         if_id_accept;

    assign pc_plus4     = pc_q + 64'd4;
    assign target       = redirect_pc & ~64'h3;
    assign imem_addr    = pc_q;
    assign imem_req     = rst & ~skid_full;
    assign handshake    = imem_req & imem_ready;
    assign if_id_accept = ~id_stall | ~if_id_q.valid;
    assign fetched      = '{valid: 1'b1, instr: imem_rdata, pc: pc_q, pc_plus4: pc_plus4};

    if_skid_buffer u_skid (
        .clk      (clk),
        .rst_n    (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .data_i   (fetched),
        .data_o   (skid_data),
        .full_o   (skid_full)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        if_id_d     = if_id_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (redirect) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
            skid_clear    = 1'b1;
            unique case (state_q)
                FETCH: begin
                    // An unaccepted request must keep its address, so park the target.
                    if (imem_req && !imem_ready) begin
                        state_d = DRAIN;
                        pend_d  = target;
                    end else begin
                        pc_d = target;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        state_d = FETCH;
                        pc_d    = target;
                    end else begin
                        pend_d = target;
                    end
                end
            endcase
        end else begin
            // Decode consumed the current entry; it becomes a bubble unless refilled.
            if (!id_stall) begin
                if_id_d.valid = 1'b0;
                if_id_d.instr = NOP_INSTR;
            end
            unique case (state_q)
                FETCH: begin
                    if (skid_full) begin
                        if (!id_stall) begin
                            if_id_d     = skid_data;
                            skid_unload = 1'b1;
                        end
                    end else if (handshake) begin
                        pc_d = pc_plus4;
                        if (if_id_accept) begin
                            if_id_d = fetched;
                        end else begin
                            skid_load = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        state_d = FETCH;
                        pc_d    = pend_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= 64'h0;
            if_id_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: 64'h0, pc_plus4: 64'h0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            if_id_q <= if_id_d;
        end
    end

    assign if_id_valid    = if_id_q.valid;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard of expected PCs is drained by a
// monitor each time decode takes an instruction, plus point checks on the handshake.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic [63:0] if_id_pc_plus4;

    logic        ready_en;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    localparam logic [31:0] NOP_WORD = 32'hD503201F;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    // Zero-wait instruction memory returning address-tagged words.
    assign imem_rdata = mem_word(imem_addr);
    assign imem_ready = ready_en;

    fetch_stage #(
        .RESET_PC  (64'h0),
        .NOP_INSTR (NOP_WORD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Decode takes IF/ID at the coming edge when valid, not stalled and not flushed.
    always @(negedge clk) begin
        if (rst && if_id_valid && !id_stall && !redirect) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_pc", if_id_pc, mon_exp);
                check("sb_pc_plus4", if_id_pc_plus4, mon_exp + 64'd4);
                check("sb_instr", 64'(if_id_instr), 64'(mem_word(mon_exp)));
            end
        end
    end

    initial begin
        rst         = 1'b1;
        ready_en    = 1'b1;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        #1 rst = 1'b0;
        #2;
        check("rst_valid", 64'(if_id_valid), 64'd0);
        check("rst_instr", 64'(if_id_instr), 64'(NOP_WORD));
        check("rst_pc", if_id_pc, 64'h0);
        check("rst_pc_plus4", if_id_pc_plus4, 64'h0);
        check("rst_req", 64'(imem_req), 64'd0);
        step(2);
        check("rst_hold_req", 64'(imem_req), 64'd0);
        check("rst_hold_valid", 64'(if_id_valid), 64'd0);

        // Streaming from RESET_PC, then a 3-cycle decode stall.
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h8);
        exp_q.push_back(64'hC);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, 64'h0);
        step();
        check("e1_valid", 64'(if_id_valid), 64'd1);
        check("e1_pc", if_id_pc, 64'h0);
        check("e1_pc_plus4", if_id_pc_plus4, 64'h4);
        step();
        check("e2_pc", if_id_pc, 64'h4);
        step();
        check("e3_pc", if_id_pc, 64'h8);
        id_stall = 1'b1;
        step();
        check("stall_skid_req", 64'(imem_req), 64'd0);
        check("stall_hold_pc", if_id_pc, 64'h8);
        step(2);
        check("stall_hold_pc2", if_id_pc, 64'h8);
        check("stall_hold_req2", 64'(imem_req), 64'd0);
        check("stall_hold_valid", 64'(if_id_valid), 64'd1);
        id_stall = 1'b0;
        step();
        check("unstall_skid_pc", if_id_pc, 64'hC);
        step();
        check("unstall_next_pc", if_id_pc, 64'h10);
        check("unstall_next_p4", if_id_pc_plus4, 64'h14);

        // Redirect while stalled with the skid full; low target bits are dropped.
        id_stall = 1'b1;
        step(2);
        check("full_skid_req", 64'(imem_req), 64'd0);
        check("full_skid_pc", if_id_pc, 64'h10);
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        step();
        redirect = 1'b0;
        check("flush_valid", 64'(if_id_valid), 64'd0);
        check("flush_instr", 64'(if_id_instr), 64'(NOP_WORD));
        check("redir_addr", imem_addr, 64'h100);
        check("redir_req", 64'(imem_req), 64'd1);
        step();
        check("redir_valid", 64'(if_id_valid), 64'd1);
        check("redir_pc", if_id_pc, 64'h100);
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h104);
        id_stall = 1'b0;
        step(2);
        check("run_pc", if_id_pc, 64'h108);

        // Slow memory at 0x20 with a redirect to 0x200 arriving mid-wait.
        redirect    = 1'b1;
        redirect_pc = 64'h20;
        step();
        redirect = 1'b0;
        ready_en = 1'b0;
        check("wait_valid", 64'(if_id_valid), 64'd0);
        check("wait_addr0", imem_addr, 64'h20);
        check("wait_req", 64'(imem_req), 64'd1);
        step();
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        check("wait_addr1", imem_addr, 64'h20);
        step();
        redirect = 1'b0;
        check("drain_addr2", imem_addr, 64'h20);
        check("drain_req", 64'(imem_req), 64'd1);
        check("drain_valid", 64'(if_id_valid), 64'd0);
        step();
        check("drain_addr3", imem_addr, 64'h20);
        step();
        ready_en = 1'b1;
        check("drain_addr4", imem_addr, 64'h20);
        step();
        check("drain_done_addr", imem_addr, 64'h200);
        check("drain_discard", 64'(if_id_valid), 64'd0);
        exp_q.push_back(64'h200);
        step();
        check("drain_first_pc", if_id_pc, 64'h200);
        check("drain_first_valid", 64'(if_id_valid), 64'd1);

        // Two redirects while draining: the newest target wins.
        ready_en = 1'b0;
        step();
        check("bubble_valid", 64'(if_id_valid), 64'd0);
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        step();
        redirect_pc = 64'h400;
        check("drain2_addr", imem_addr, 64'h204);
        step();
        redirect = 1'b0;
        ready_en = 1'b1;
        check("drain2_addr_hold", imem_addr, 64'h204);
        check("drain2_req", 64'(imem_req), 64'd1);
        step();
        check("newest_addr", imem_addr, 64'h400);
        check("newest_discard", 64'(if_id_valid), 64'd0);
        exp_q.push_back(64'h400);
        step();
        check("newest_pc", if_id_pc, 64'h400);
        step();
        check("newest_next_pc", if_id_pc, 64'h404);

        // Asynchronous reset mid-stall with the skid full.
        id_stall = 1'b1;
        step();
        check("pre_rst_req", 64'(imem_req), 64'd0);
        check("pre_rst_pc", if_id_pc, 64'h404);
        #2 rst = 1'b0;
        #1;
        check("async_valid", 64'(if_id_valid), 64'd0);
        check("async_instr", 64'(if_id_instr), 64'(NOP_WORD));
        check("async_pc", if_id_pc, 64'h0);
        check("async_pc_plus4", if_id_pc_plus4, 64'h0);
        check("async_req", 64'(imem_req), 64'd0);
        check("async_addr", imem_addr, 64'h0);
        id_stall = 1'b0;
        step(2);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("restart_req", 64'(imem_req), 64'd1);
        check("restart_addr", imem_addr, 64'h0);
        step();
        check("restart_pc0", if_id_pc, 64'h0);
        step();
        check("restart_pc1", if_id_pc, 64'h4);
        step();
        check("restart_pc2", if_id_pc, 64'h8);
        id_stall = 1'b1;
        step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipelined CPU, directly upstream of decode.
- Owns the program counter and generates instruction-memory requests through a req/ready handshake.
- Absorbs decode stalls in a one-entry skid buffer.
- Applies branch redirects and flushes from later stages, and drives the IF/ID pipeline register (instruction, PC, PC+4, valid).

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INSTR, 32'hD503201F, instruction word presented on if_id_instr when if_id_valid=0.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion synchronised externally.
imem_addr  output  64  fetch address; held stable while imem_req=1 and imem_ready=0.
imem_req  output  1  fetch request.
imem_ready  input  1  handshake; imem_rdata valid when imem_req & imem_ready at posedge.
imem_rdata  input  32  instruction word.
id_stall  input  1  decode cannot accept; IF/ID holds.
redirect  input  1  taken branch / BR / BL resolved downstream; also flushes IF/ID.
redirect_pc  input  64  new fetch target, word-aligned.
if_id_valid  output  1  IF/ID holds a real instruction.
if_id_instr  output  32  instruction to decode.
if_id_pc  output  64  address of if_id_instr.
if_id_pc_plus4  output  64  if_id_pc+4, used for BL link value.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH, skid empty.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0.
  - imem_req=0 while rst=0; after release, req=1 on the first cycle.
- imem_addr=pc in FETCH; imem_req=1 in FETCH and DRAIN unless the skid is full.
- Handshake completes at a posedge with imem_req & imem_ready. imem_ready may be combinational (0-wait) or arrive N cycles later.
- States:
  - FETCH: normal.
  - DRAIN: redirect arrived while a request was outstanding and unaccepted.
- FETCH, handshake completes, no redirect:
  - If IF/ID can accept (id_stall=0 or if_id_valid=0), load if_id_* with {imem_rdata, pc, pc+4}, valid=1.
  - Otherwise write the skid.
  - pc <= pc+4 (64-bit wrap, no flag).
- FETCH, imem_req=1, no handshake, redirect=1:
  - Latch pend_pc <= redirect_pc and go to DRAIN.
  - imem_addr remains old pc until accepted.
- DRAIN, handshake completes: discard imem_rdata, pc <= pend_pc, go to FETCH.
- DRAIN, another redirect: pend_pc overwritten; newest redirect wins.
- FETCH, redirect with handshake completing the same cycle, or no request outstanding: discard data, pc <= redirect_pc, stay FETCH.
- Redirect always flushes:
  - if_id_valid <= 0 and if_id_instr <= NOP_INSTR on the next edge, overriding id_stall.
  - Skid cleared.
- id_stall=1 and if_id_valid=1, no redirect:
  - IF/ID holds all fields.
  - One further instruction may complete into the skid; imem_req=0 while the skid is full and pc holds.
- id_stall falls with skid full: IF/ID <= skid contents and skid empties. One cycle later, fetch resumes.
- Priority: rst > redirect > id_stall > normal advance.
- redirect_pc bits[1:0] are ignored (forced to 0).
- Latency:
  - Zero-wait memory gives 1 instruction/cycle.
  - A redirect produces the first new if_id_valid 1 cycle after the redirect edge with 0-wait memory.

Decomposition:
- Shared package cpu_pkg:
  - NOP constant.
  - fetch_state_t enum {FETCH, DRAIN}.
  - if_id_t struct {valid, instr[31:0], pc[63:0], pc_plus4[63:0]}, reused by decode_stage.
- One sub-module: if_skid_buffer, a one-entry holding register of if_id_t with load/unload/clear.
- PC+4 uses the existing 64-bit adder.

Test Plan:
1. Reset with RESET_PC=0, 0-wait memory, rdata=addr-tagged words -> if_id_pc sequence 0,4,8,C on consecutive cycles; if_id_pc_plus4 = pc+4; valid=1 from the 2nd cycle after reset release.
2. id_stall=1 for 3 cycles with if_id_pc=8 -> IF/ID holds 8; skid holds 0xC; imem_req=0 after skid fill; on release IF/ID shows 0xC then 0x10 with no loss or duplication.
3. redirect=1, redirect_pc=0x100 while id_stall=1 -> next edge if_id_valid=0 and instr=D503201F; next valid instruction has pc=0x100; skid content discarded.
4. imem_ready=0 for 4 cycles at pc=0x20, redirect to 0x200 in cycle 2 -> imem_addr stays 0x20 until ready; that data is discarded; next request addr=0x200.
5. Two redirects (0x300 then 0x400) during DRAIN -> first fetch after drain is 0x400.
6. rst pulled low mid-stall with skid full -> outputs immediately return to reset values without waiting for clk; after release, fetch restarts at RESET_PC.
